// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port 128-word test-bench RAM between the CPU
// (port 0) and the I/O / loader requester (port 1).
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN.
//   undefined -> fixed priority, port 0 wins every conflict.
//   defined   -> on conflict the port not granted last wins; a lone request is
//                always granted.
//
// Handshake: reqN is held high with weN/addrN/wdataN stable until ackN, which
// is a one-cycle pulse. rdataN is valid during ackN and holds until that
// port's next ack. Requests are only sampled in IDLE; a req still high in IDLE
// after its ack is a new access.
//
// fsm_state exposes the controller state (0 IDLE, 1 ACCESS, 2 ACK).
module mem_arbiter #(
   parameter int ACCESS_CYCLES = 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [15:31]  addr0,
   input  logic [15:31]  addr1,
   input  logic [0:31]   wdata0,
   input  logic [0:31]   wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [0:31]   rdata0,
   output logic [0:31]   rdata1,
   output logic [15:31]  mem_addr,
   output logic          mem_we,
   output logic [0:31]   mem_wdata,
   input  logic [0:31]   mem_rdata,
   output logic          busy,
   output logic          owner,
   output logic [1:0]    fsm_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   localparam logic [3:0] COUNT_INIT = 4'(ACCESS_CYCLES - 1);

   state_t     state;
   state_t     state_next;
   logic [3:0] count;
   logic       lat_we;
   logic       grant_valid;
   logic       grant_port;
   logic       cnt_zero;

   assign grant_valid = req0 | req1;
   assign cnt_zero    = (count == 4'd0);
   assign fsm_state   = state;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_grant;

   // Conflict goes to the port not granted last; a lone request always wins.
   always_comb begin
      grant_port = 1'b0;
      if (req0 && req1) begin
         grant_port = ~last_grant;
      end else begin
         grant_port = ~req0;
      end
   end

   // Remember every grant; reset to 1 so the first conflict goes to port 0.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_grant <= 1'b1;
      end else if (state == IDLE && grant_valid) begin
         last_grant <= grant_port;
      end
   end
`else
   // Fixed priority: port 0 wins whenever it is requesting.
   always_comb begin
      grant_port = ~req0;
   end
`endif

   // Controller state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state plus decoded strobes; mem_we pulses only in the last ACCESS cycle.
   always_comb begin
      state_next = state;
      mem_we     = 1'b0;
      ack0       = 1'b0;
      ack1       = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            busy   = 1'b1;
            mem_we = lat_we & cnt_zero;
            if (cnt_zero) begin
               state_next = ACK;
            end
         end
         ACK: begin
            busy       = 1'b1;
            ack0       = ~owner;
            ack1       = owner;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Latch the winner's request, run the access counter, capture read data.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count     <= 4'd0;
         lat_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         owner     <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  owner     <= grant_port;
                  lat_we    <= grant_port ? we1 : we0;
                  mem_addr  <= grant_port ? addr1 : addr0;
                  mem_wdata <= grant_port ? wdata1 : wdata0;
                  count     <= COUNT_INIT;
               end
            end
            ACCESS: begin
               if (!cnt_zero) begin
                  count <= count - 4'd1;
               end else if (owner) begin
                  rdata1 <= mem_rdata;
               end else begin
                  rdata0 <= mem_rdata;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiter instances (ACCESS_CYCLES = 1, 3, 4), each with
// its own 128-word RAM. A transaction-level model (shadow memory, last-grant
// memory, latency formula N+1, ack spacing N+2) predicts every result.
module tb_mem_arbiter;

   localparam int NI = 3;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          rst_s      [NI];
   logic          req0_s     [NI];
   logic          req1_s     [NI];
   logic          we0_s      [NI];
   logic          we1_s      [NI];
   logic [15:31]  addr0_s    [NI];
   logic [15:31]  addr1_s    [NI];
   logic [0:31]   wdata0_s   [NI];
   logic [0:31]   wdata1_s   [NI];
   logic          ack0_s     [NI];
   logic          ack1_s     [NI];
   logic [0:31]   rdata0_s   [NI];
   logic [0:31]   rdata1_s   [NI];
   logic [15:31]  mem_addr_s [NI];
   logic          mem_we_s   [NI];
   logic [0:31]   mem_wdata_s[NI];
   logic [0:31]   mem_rdata_s[NI];
   logic          busy_s     [NI];
   logic          owner_s    [NI];
   logic [1:0]    state_s    [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mem_arbiter #(.ACCESS_CYCLES(g == 0 ? 1 : (g == 1 ? 3 : 4))) dut (
         .clock    (clock),
         .reset    (rst_s[g]),
         .req0     (req0_s[g]),
         .req1     (req1_s[g]),
         .we0      (we0_s[g]),
         .we1      (we1_s[g]),
         .addr0    (addr0_s[g]),
         .addr1    (addr1_s[g]),
         .wdata0   (wdata0_s[g]),
         .wdata1   (wdata1_s[g]),
         .ack0     (ack0_s[g]),
         .ack1     (ack1_s[g]),
         .rdata0   (rdata0_s[g]),
         .rdata1   (rdata1_s[g]),
         .mem_addr (mem_addr_s[g]),
         .mem_we   (mem_we_s[g]),
         .mem_wdata(mem_wdata_s[g]),
         .mem_rdata(mem_rdata_s[g]),
         .busy     (busy_s[g]),
         .owner    (owner_s[g]),
         .fsm_state(state_s[g])
      );
   end

   // ---------------- RAM models (environment) ----------------
   logic [0:31] ram [NI][128];
   logic        ram_clr;

   always @(posedge clock) begin
      for (int k = 0; k < NI; k++) begin
         if (ram_clr) begin
            for (int i = 0; i < 128; i++) ram[k][i] <= '0;
         end else if (mem_we_s[k]) begin
            ram[k][mem_addr_s[k][25:31]] <= mem_wdata_s[k];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NI; k++) mem_rdata_s[k] = ram[k][mem_addr_s[k][25:31]];
   end

   // ---------------- reference model ----------------
   logic [0:31] shadow [NI][128];
   int          last_gnt [NI];

   function automatic int n_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
   endfunction

   // Which port the spec says wins, given the pending requests.
   function automatic int pick(input int k, input bit r0, input bit r1);
      if (r0 && r1) return RR ? (1 - last_gnt[k]) : 0;
      return r0 ? 0 : 1;
   endfunction

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_port(input int k, input int p, input bit rq, input bit we,
                             input logic [15:31] a, input logic [0:31] d);
      if (p == 0) begin
         req0_s[k] = rq; we0_s[k] = we; addr0_s[k] = a; wdata0_s[k] = d;
      end else begin
         req1_s[k] = rq; we1_s[k] = we; addr1_s[k] = a; wdata1_s[k] = d;
      end
   endtask

   // One lone access on port p, checked for latency, pulses, data and owner.
   task automatic do_access(input int k, input int p, input bit we,
                            input logic [15:31] a, input logic [0:31] d);
      int cyc, wcnt, bcnt, oth, n;
      bit got;
      logic [0:31] rd;
      n = n_of(k);
      cyc = 0; wcnt = 0; bcnt = 0; oth = 0; got = 1'b0; rd = '0;
      @(negedge clock);
      drive_port(k, p, 1'b1, we, a, d);
      while (!got && cyc < 64) begin
         @(negedge clock);
         cyc++;
         if (busy_s[k]) bcnt++;
         if (mem_we_s[k]) begin
            wcnt++;
            check_eq("mem_addr_at_we", mem_addr_s[k], a);
            check_eq("mem_wdata_at_we", mem_wdata_s[k], d);
         end
         if ((p == 0) ? ack1_s[k] : ack0_s[k]) oth++;
         if ((p == 0) ? ack0_s[k] : ack1_s[k]) begin
            got = 1'b1;
            rd  = (p == 0) ? rdata0_s[k] : rdata1_s[k];
         end
      end
      drive_port(k, p, 1'b0, 1'b0, a, d);
      check_eq("ack_seen", got, 1);
      check_eq("latency", cyc, n + 1);
      check_eq("we_pulses", wcnt, we ? 1 : 0);
      check_eq("busy_cycles", bcnt, n + 1);
      check_eq("other_ack", oth, 0);
      check_eq("owner", owner_s[k], pick(k, p == 0, p == 1));
      if (we) shadow[k][a[25:31]] = d;
      else check_eq("rdata", rd, shadow[k][a[25:31]]);
      last_gnt[k] = p;
   endtask

   // Both ports hold read requests for `total` grants.
   task automatic do_conflict(input int k, input int total);
      int cyc, prev, cnt, g, e, n;
      logic [15:31] a0, a1;
      logic [0:31] rd;
      n = n_of(k); cyc = 0; prev = 0; cnt = 0;
      a0 = 17'h00030; a1 = 17'h00031;
      @(negedge clock);
      drive_port(k, 0, 1'b1, 1'b0, a0, '0);
      drive_port(k, 1, 1'b1, 1'b0, a1, '0);
      while (cnt < total && cyc < 400) begin
         @(negedge clock);
         cyc++;
         check_eq("ack_onehot", ack0_s[k] & ack1_s[k], 0);
         if (ack0_s[k] || ack1_s[k]) begin
            g = ack1_s[k] ? 1 : 0;
            e = pick(k, 1'b1, 1'b1);
            check_eq("grant_order", g, e);
            check_eq("ack_spacing", cyc - prev, (cnt == 0) ? n + 1 : n + 2);
            rd = (g == 0) ? rdata0_s[k] : rdata1_s[k];
            check_eq("conflict_rdata", rd, shadow[k][(g == 0) ? 7'h30 : 7'h31]);
            last_gnt[k] = g;
            prev = cyc;
            cnt++;
            if (cnt == total) begin
               drive_port(k, 0, 1'b0, 1'b0, a0, '0);
               drive_port(k, 1, 1'b0, 1'b0, a1, '0);
            end
         end
      end
      check_eq("conflict_done", cnt, total);
      drive_port(k, 0, 1'b0, 1'b0, a0, '0);
      drive_port(k, 1, 1'b0, 1'b0, a1, '0);
   endtask

   // Reset lands in the 2nd ACCESS cycle of a write: nothing must happen.
   task automatic reset_mid_write(input int k);
      int wcnt, acks;
      wcnt = 0; acks = 0;
      @(negedge clock);
      drive_port(k, 0, 1'b1, 1'b1, 17'h00020, 32'hCAFEF00D);
      repeat (2) begin
         @(negedge clock);
         if (mem_we_s[k]) wcnt++;
         if (ack0_s[k] || ack1_s[k]) acks++;
      end
      rst_s[k] = 1'b0;
      #1;
      check_eq("rst_mid_mem_we", mem_we_s[k], 0);
      check_eq("rst_mid_busy", busy_s[k], 0);
      check_eq("rst_mid_state", state_s[k], 0);
      drive_port(k, 0, 1'b0, 1'b0, 17'h00020, 32'hCAFEF00D);
      repeat (2) begin
         @(negedge clock);
         if (mem_we_s[k]) wcnt++;
         if (ack0_s[k] || ack1_s[k]) acks++;
      end
      rst_s[k] = 1'b1;
      last_gnt[k] = 1;
      repeat (8) begin
         @(negedge clock);
         if (mem_we_s[k]) wcnt++;
         if (ack0_s[k] || ack1_s[k]) acks++;
      end
      check_eq("rst_mid_we_count", wcnt, 0);
      check_eq("rst_mid_acks", acks, 0);
      check_eq("rst_mid_idle", state_s[k], 0);
      check_eq("rst_mid_word", ram[k][7'h20], shadow[k][7'h20]);
   endtask

   // Port 1 arrives during port 0's ACCESS; it must wait for the next IDLE.
   task automatic late_requester(input int k);
      int cyc, c0, c1, n;
      bit d0, d1;
      logic [0:31] d, r;
      n = n_of(k); cyc = 0; c0 = -1; c1 = -1; d0 = 1'b0; d1 = 1'b0;
      d = $urandom; r = '0;
      @(negedge clock);
      drive_port(k, 0, 1'b1, 1'b1, 17'h00020, d);
      while (!d1 && cyc < 100) begin
         @(negedge clock);
         cyc++;
         if (cyc == 2) drive_port(k, 1, 1'b1, 1'b0, 17'h00020, '0);
         if (ack0_s[k] && !d0) begin
            d0 = 1'b1; c0 = cyc;
            drive_port(k, 0, 1'b0, 1'b0, 17'h00020, d);
         end
         if (ack1_s[k] && !d1) begin
            d1 = 1'b1; c1 = cyc; r = rdata1_s[k];
            drive_port(k, 1, 1'b0, 1'b0, 17'h00020, '0);
         end
      end
      check_eq("late_ack0_cycle", c0, n + 1);
      check_eq("late_ack1_cycle", c1, (n + 1) + 1 + (n + 1));
      shadow[k][7'h20] = d;
      check_eq("late_rdata1", r, shadow[k][7'h20]);
      last_gnt[k] = 1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      ram_clr = 1'b1;
      for (int k = 0; k < NI; k++) begin
         rst_s[k] = 1'b0;
         drive_port(k, 0, 1'b1, 1'b1, 17'($urandom), $urandom);
         drive_port(k, 1, 1'b1, 1'b0, 17'($urandom), $urandom);
         last_gnt[k] = 1;
         for (int i = 0; i < 128; i++) shadow[k][i] = '0;
      end
      repeat (3) begin
         @(negedge clock);
         for (int k = 0; k < NI; k++) begin
            check_eq("rst_ack0", ack0_s[k], 0);
            check_eq("rst_ack1", ack1_s[k], 0);
            check_eq("rst_mem_we", mem_we_s[k], 0);
            check_eq("rst_mem_addr", mem_addr_s[k], 0);
            check_eq("rst_busy", busy_s[k], 0);
            check_eq("rst_owner", owner_s[k], 0);
         end
      end
      for (int k = 0; k < NI; k++) begin
         req0_s[k] = 1'b0;
         req1_s[k] = 1'b0;
      end
      @(negedge clock);
      ram_clr = 1'b0;
      for (int k = 0; k < NI; k++) rst_s[k] = 1'b1;

      // N = 1: write then read back on port 0
      do_access(0, 0, 1'b1, 17'h00010, 32'hDEADBEEF);
      do_access(0, 0, 1'b0, 17'h00010, 32'h0);
      @(negedge clock);
      check_eq("rdata0_hold", rdata0_s[0], 32'hDEADBEEF);

      // N = 3: preload then stretched read on port 1
      do_access(1, 0, 1'b1, 17'h00005, 32'h12345678);
      do_access(1, 1, 1'b0, 17'h00005, 32'h0);
      do_access(1, 0, 1'b1, 17'h00030, $urandom);
      do_access(1, 1, 1'b1, 17'h00031, $urandom);
      do_conflict(1, 4);

      do_access(0, 0, 1'b1, 17'h00030, $urandom);
      do_access(0, 1, 1'b1, 17'h00031, $urandom);
      do_conflict(0, 4);

      // N = 4: reset mid-write, then late requester
      do_access(2, 1, 1'b1, 17'h00020, 32'h11111111);
      reset_mid_write(2);
      do_access(2, 0, 1'b0, 17'h00020, 32'h0);
      late_requester(2);

      // randomized lone accesses followed by a short conflict burst
      for (int k = 0; k < NI; k++) begin
         for (int t = 0; t < 15; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            do_access(k, $urandom_range(0, 1), 1'($urandom_range(0, 1)),
                      17'($urandom_range(0, 127)), $urandom);
         end
         do_conflict(k, 3);
      end

      repeat (3) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
